// File: rtl/cache_set_ctrl.sv
// Lookup/refill controller for one 8-way set: tag compare, victim choice
// (first invalid way, else tree pseudo-LRU), memory refill handshake and set write-back.
module cache_set_ctrl #(
  parameter int TAG_W = 24
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [TAG_W-1:0] req_tag,
  input  logic             flush,
  output logic             resp_valid,
  output logic             resp_hit,
  output logic [2:0]       resp_way,
  input  logic [7:0]       out_viv,
  input  logic [TAG_W-1:0] tag0,
  input  logic [TAG_W-1:0] tag1,
  input  logic [TAG_W-1:0] tag2,
  input  logic [TAG_W-1:0] tag3,
  input  logic [TAG_W-1:0] tag4,
  input  logic [TAG_W-1:0] tag5,
  input  logic [TAG_W-1:0] tag6,
  input  logic [TAG_W-1:0] tag7,
  output logic             regWrite,
  output logic [7:0]       decOut1b_viv,
  output logic [7:0]       inp_viv,
  output logic [TAG_W-1:0] new_tag,
  output logic             mem_req,
  output logic [TAG_W-1:0] mem_tag,
  input  logic             mem_ack
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    LOOKUP = 3'd1,
    MISS   = 3'd2,
    FILL   = 3'd3,
    FLUSH  = 3'd4,
    RESP   = 3'd5
  } state_t;

  state_t           state_q, state_d;
  logic [TAG_W-1:0] tag_q, tag_d;
  logic [2:0]       way_q, way_d;
  logic             hit_q, hit_d;
  logic [6:0]       plru_q, plru_d;

  logic [TAG_W-1:0] tag_arr [8];
  logic [7:0]       match;
  logic             hit_any;
  logic [2:0]       hit_idx;
  logic             inv_any;
  logic [2:0]       inv_idx;
  logic [2:0]       victim_way;
  logic             victim_mid;
  logic             victim_leaf;

  assign tag_arr[0] = tag0;
  assign tag_arr[1] = tag1;
  assign tag_arr[2] = tag2;
  assign tag_arr[3] = tag3;
  assign tag_arr[4] = tag4;
  assign tag_arr[5] = tag5;
  assign tag_arr[6] = tag6;
  assign tag_arr[7] = tag7;

  generate
    for (genvar gi = 0; gi < 8; gi++) begin : g_match
      assign match[gi] = out_viv[gi] & (tag_arr[gi] == tag_q);
    end
  endgenerate

  // Priority encoders: the downward loop leaves the lowest qualifying index.
  always_comb begin
    hit_idx = 3'd0;
    inv_idx = 3'd0;
    for (int i = 7; i >= 0; i--) begin
      if (match[i])    hit_idx = 3'(i);
      if (!out_viv[i]) inv_idx = 3'(i);
    end
    hit_any = |match;
    inv_any = ~&out_viv;
  end

  always_comb begin
    victim_mid  = plru_q[0] ? plru_q[2] : plru_q[1];
    victim_leaf = 1'b0;
    case ({plru_q[0], victim_mid})
      2'b00:   victim_leaf = plru_q[3];
      2'b01:   victim_leaf = plru_q[4];
      2'b10:   victim_leaf = plru_q[5];
      default: victim_leaf = plru_q[6];
    endcase
    victim_way = {plru_q[0], victim_mid, victim_leaf};
  end

  // Point every tree node on the path to w away from w.
  function automatic logic [6:0] plru_touch(input logic [6:0] plru, input logic [2:0] w);
    logic [6:0] n;
    n    = plru;
    n[0] = ~w[2];
    if (w[2]) n[2] = ~w[1];
    else      n[1] = ~w[1];
    case (w[2:1])
      2'b00:   n[3] = ~w[0];
      2'b01:   n[4] = ~w[0];
      2'b10:   n[5] = ~w[0];
      default: n[6] = ~w[0];
    endcase
    return n;
  endfunction

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      tag_q   <= '0;
      way_q   <= 3'd0;
      hit_q   <= 1'b0;
      plru_q  <= 7'd0;
    end else begin
      state_q <= state_d;
      tag_q   <= tag_d;
      way_q   <= way_d;
      hit_q   <= hit_d;
      plru_q  <= plru_d;
    end
  end

  always_comb begin
    state_d = state_q;
    tag_d   = tag_q;
    way_d   = way_q;
    hit_d   = hit_q;
    plru_d  = plru_q;
    case (state_q)
      IDLE: begin
        if (flush) begin
          state_d = FLUSH;
        end else if (req_valid) begin
          tag_d   = req_tag;
          state_d = LOOKUP;
        end
      end
      LOOKUP: begin
        if (hit_any) begin
          way_d   = hit_idx;
          hit_d   = 1'b1;
          plru_d  = plru_touch(plru_q, hit_idx);
          state_d = RESP;
        end else begin
          way_d   = inv_any ? inv_idx : victim_way;
          hit_d   = 1'b0;
          state_d = MISS;
        end
      end
      MISS: begin
        if (mem_ack) state_d = FILL;
      end
      FILL: begin
        plru_d  = plru_touch(plru_q, way_q);
        state_d = RESP;
      end
      FLUSH: begin
        plru_d  = 7'd0;
        state_d = IDLE;
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // A simultaneous flush wins, so the request is not reported as accepted.
  always_comb begin
    req_ready    = 1'b0;
    resp_valid   = 1'b0;
    resp_hit     = 1'b0;
    resp_way     = 3'd0;
    regWrite     = 1'b0;
    decOut1b_viv = 8'h00;
    inp_viv      = 8'h00;
    mem_req      = 1'b0;
    new_tag      = tag_q;
    mem_tag      = tag_q;
    case (state_q)
      IDLE: req_ready = ~flush;
      MISS: mem_req = 1'b1;
      FILL: begin
        regWrite     = 1'b1;
        decOut1b_viv = 8'h01 << way_q;
        inp_viv      = 8'hFF;
      end
      FLUSH: begin
        regWrite     = 1'b1;
        decOut1b_viv = 8'hFF;
      end
      RESP: begin
        resp_valid = 1'b1;
        resp_hit   = hit_q;
        resp_way   = way_q;
      end
      default: ;
    endcase
  end

endmodule
